// File: rtl/sipo_word_assembler_if.sv
// Serial-in / word-out bundle between a bit-stream source and its word consumer.
// The master drives bits, framing and the consumer handshake; the slave returns words and status.
interface sipo_word_assembler_if #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 2
);
    logic                          serial_in;
    logic                          bit_valid;
    logic                          frame_start;
    logic                          word_ready;
    logic                          ovf_clr;
    logic [WIDTH-1:0]              word_out;
    logic                          word_valid;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic [$clog2(WIDTH)-1:0]      bit_count;
    logic                          overflow;
    logic                          sync_err;

    modport master (
        output serial_in, bit_valid, frame_start, word_ready, ovf_clr,
        input  word_out, word_valid, level, bit_count, overflow, sync_err
    );

    modport slave (
        input  serial_in, bit_valid, frame_start, word_ready, ovf_clr,
        output word_out, word_valid, level, bit_count, overflow, sync_err
    );
endinterface

// File: rtl/sipo_word_assembler.sv
// Gated serial bits -> framed WIDTH-bit words -> small FIFO; word visible 1 cycle after its last bit.
// Consumer stalls via word_ready; a word completing into a full, non-popping FIFO is dropped (sticky overflow).

module sipo_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_vld,
    output logic [W-1:0]             head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign do_pop   = pop_vld && !empty;
    // A simultaneous pop frees the slot the push lands in, so full only blocks a lone push.
    assign do_push  = push_vld && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

module sipo_word_assembler #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sipo_word_assembler_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_count;
    logic             word_done;
    logic             fifo_empty;
    logic             fifo_full;
    logic             drop;
    logic             overflow_q;
    logic             sync_err_q;

    // frame_start throws the partial away, so the new bit shifts into a clean register.
    always_comb begin
        base = bus.frame_start ? '0 : shreg;
        if (MSB_FIRST != 0) begin
            shifted = {base[WIDTH-2:0], bus.serial_in};
        end else begin
            shifted = {bus.serial_in, base[WIDTH-1:1]};
        end
        word_done = bus.bit_valid && !bus.frame_start && (bit_count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_count  <= '0;
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= bus.frame_start && (bit_count != '0);
            if (bus.bit_valid) begin
                shreg <= shifted;
                if (word_done) begin
                    bit_count <= '0;
                end else if (bus.frame_start) begin
                    bit_count <= CW'(1);
                end else begin
                    bit_count <= bit_count + 1'b1;
                end
            end else if (bus.frame_start) begin
                shreg     <= '0;
                bit_count <= '0;
            end
        end
    end

    sipo_fifo #(
        .W     (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (word_done),
        .push_dat (shifted),
        .pop_vld  (bus.word_ready),
        .head_dat (bus.word_out),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (bus.level)
    );

    // Full implies non-empty, so word_ready alone decides whether a pop makes room.
    assign drop = word_done && fifo_full && !bus.word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.word_valid = !fifo_empty;
    assign bus.bit_count  = bit_count;
    assign bus.overflow   = overflow_q;
    assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_sipo_word_assembler.sv
// Drives an MSB-first and an LSB-first assembler with one stimulus stream and checks
// both every cycle against a queue-based model of bits, words and the output buffer.
module tb_sipo_word_assembler;
    localparam int W = 8;
    localparam int D = 2;

    logic clk;
    logic rst_n;
    logic sin, bv, fs, rdy, clr;

    int n_tests = 0;
    int n_fail  = 0;

    sipo_word_assembler_if #(.WIDTH(W), .FIFO_DEPTH(D)) bus_m ();
    sipo_word_assembler_if #(.WIDTH(W), .FIFO_DEPTH(D)) bus_l ();

    assign bus_m.serial_in   = sin;
    assign bus_m.bit_valid   = bv;
    assign bus_m.frame_start = fs;
    assign bus_m.word_ready  = rdy;
    assign bus_m.ovf_clr     = clr;
    assign bus_l.serial_in   = sin;
    assign bus_l.bit_valid   = bv;
    assign bus_l.frame_start = fs;
    assign bus_l.word_ready  = rdy;
    assign bus_l.ovf_clr     = clr;

    sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1), .FIFO_DEPTH(D)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_m)
    );

    sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(0), .FIFO_DEPTH(D)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per instance: 0 = MSB-first, 1 = LSB-first.
    bit         pb [2][$];
    logic [7:0] fq [2][$];
    bit         e_ovf [2];
    bit         e_sync [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        bit         pop, done, drop;
        logic [7:0] w;
        pop  = (fq[k].size() != 0) && rdy;
        done = 1'b0;
        drop = 1'b0;
        w    = '0;
        e_sync[k] = fs && (pb[k].size() != 0);
        if (fs) pb[k].delete();
        if (bv) begin
            pb[k].push_back(sin);
            if (pb[k].size() == W) begin
                for (int i = 0; i < W; i++) begin
                    if (k == 0) w[W-1-i] = pb[k][i];
                    else        w[i]     = pb[k][i];
                end
                done = 1'b1;
                pb[k].delete();
            end
        end
        if (pop) void'(fq[k].pop_front());
        if (done) begin
            if (fq[k].size() < D) fq[k].push_back(w);
            else drop = 1'b1;
        end
        if (drop) e_ovf[k] = 1'b1;
        else if (clr) e_ovf[k] = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    pb[k].delete();
                    fq[k].delete();
                    e_ovf[k]  = 1'b0;
                    e_sync[k] = 1'b0;
                end
            end else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    task automatic cmp(input int k, input logic [7:0] wo, input logic wv, input logic [1:0] lv,
                       input logic [2:0] bc, input logic of, input logic se);
        string p;
        p = (k == 0) ? "msb" : "lsb";
        chk({p, "_word_valid"}, wv, fq[k].size() != 0);
        chk({p, "_level"}, lv, fq[k].size());
        chk({p, "_bit_count"}, bc, pb[k].size());
        chk({p, "_overflow"}, of, e_ovf[k]);
        chk({p, "_sync_err"}, se, e_sync[k]);
        if (fq[k].size() != 0) chk({p, "_word_out"}, wo, fq[k][0]);
        else if (!rst_n) chk({p, "_word_out_rst"}, wo, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp(0, bus_m.word_out, bus_m.word_valid, bus_m.level, bus_m.bit_count,
                bus_m.overflow, bus_m.sync_err);
            cmp(1, bus_l.word_out, bus_l.word_valid, bus_l.level, bus_l.bit_count,
                bus_l.overflow, bus_l.sync_err);
        end
    end

    task automatic step(input logic s, input logic v, input logic f, input logic r, input logic c);
        @(negedge clk);
        sin = s; bv = v; fs = f; rdy = r; clr = c;
    endtask

    task automatic send_word(input logic [7:0] w, input logic r, input logic r_last, input logic c_last);
        for (int i = 0; i < 8; i++) begin
            step(w[7-i], 1'b1, 1'b0, (i == 7) ? r_last : r, (i == 7) ? c_last : 1'b0);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_m_word_out"}, bus_m.word_out, 0);
        chk({nm, "_m_word_valid"}, bus_m.word_valid, 0);
        chk({nm, "_m_level"}, bus_m.level, 0);
        chk({nm, "_m_bit_count"}, bus_m.bit_count, 0);
        chk({nm, "_m_overflow"}, bus_m.overflow, 0);
        chk({nm, "_m_sync_err"}, bus_m.sync_err, 0);
        chk({nm, "_l_word_out"}, bus_l.word_out, 0);
        chk({nm, "_l_level"}, bus_l.level, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t2;
        int         pct;
        rst_n = 1'b0;
        sin = 0; bv = 0; fs = 0; rdy = 0; clr = 0;
        repeat (3) step(0, 0, 0, 0, 0);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Back-to-back bits 1,0,1,1,0,0,1,0 with the consumer ready.
        send_word(8'hB2, 1'b1, 1'b1, 1'b0);
        step(0, 0, 0, 1, 0);
        chk("t1_valid", bus_m.word_valid, 1);
        chk("t1_word_msb", bus_m.word_out, 8'hB2);
        chk("t1_word_lsb", bus_l.word_out, 8'h4D);
        chk("t1_level", bus_m.level, 1);
        step(0, 0, 0, 1, 0);
        chk("t1_level_after_pop", bus_m.level, 0);

        // Same stream with two idle cycles after every bit.
        t2 = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            step(t2[7-i], 1, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            if (i == 2) chk("t2_bit_count3", bus_l.bit_count, 3);
            step(0, 0, 0, 0, 0);
        end
        chk("t2_word_lsb", bus_l.word_out, 8'h4D);
        chk("t2_bit_count0", bus_l.bit_count, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Three words into a two-entry buffer with no consumer.
        send_word(8'hA5, 0, 0, 0);
        send_word(8'h3C, 0, 0, 0);
        send_word(8'hF0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t3_level", bus_m.level, 2);
        chk("t3_head", bus_m.word_out, 8'hA5);
        chk("t3_overflow", bus_m.overflow, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("t3_second", bus_m.word_out, 8'h3C);
        step(0, 0, 0, 0, 0);
        chk("t3_empty", bus_m.word_valid, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("t3_ovf_clr", bus_m.overflow, 0);

        // Word completes into a full buffer while the consumer pops.
        send_word(8'h11, 0, 0, 0);
        send_word(8'h22, 0, 0, 0);
        send_word(8'h33, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("t4_level", bus_m.level, 2);
        chk("t4_no_ovf", bus_m.overflow, 0);
        chk("t4_head", bus_m.word_out, 8'h22);
        send_word(8'h44, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("t4_set_wins", bus_m.overflow, 1);
        chk("t4_head_kept", bus_m.word_out, 8'h22);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("t4_drained", bus_m.level, 0);
        chk("t4_cleared", bus_m.overflow, 0);

        // Realignment in the middle of a word.
        repeat (3) step(1, 1, 0, 0, 0);
        t2 = 8'h5A;
        step(t2[7], 1, 1, 0, 0);
        for (int i = 1; i < 8; i++) begin
            step(t2[7-i], 1, 0, 0, 0);
            if (i == 1) begin
                chk("t5_sync_pulse", bus_m.sync_err, 1);
                chk("t5_bit_count1", bus_m.bit_count, 1);
            end
            if (i == 2) chk("t5_sync_once", bus_m.sync_err, 0);
        end
        step(0, 0, 1, 1, 0);
        chk("t5_word", bus_m.word_out, 8'h5A);
        chk("t5_level", bus_m.level, 1);
        step(0, 0, 0, 0, 0);
        chk("t5_aligned_no_sync", bus_m.sync_err, 0);

        // Asynchronous reset mid-word with a word buffered.
        send_word(8'h77, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async_rst");
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        send_word(8'h81, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t6_word", bus_m.word_out, 8'h81);
        chk("t6_level", bus_m.level, 1);

        // Random traffic, alternating mostly-ready and mostly-stalled phases.
        for (int i = 0; i < 4000; i++) begin
            pct = ((i / 200) % 2 == 1) ? 85 : 15;
            step(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) < pct, $urandom_range(0, 29) == 0);
        end
        step(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
